ripple_borrow_subtractor_serial: RTL and testbench
==================================================

// Module: ripple_borrow_subtractor_serial
// PURPOSE
//   Bit-serial ripple-borrow subtractor that computes diff = a - b - bin, one bit per clock, LSB first.
//   It is the inverse-direction companion to the 4-bit ripple carry adder.
//   Trades latency for area: one full-subtractor cell plus shift registers.
//   Uses a start/busy/done handshake so a sequencer can issue subtractions and collect results.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2); counter width = $clog2(WIDTH)+1
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   diff   out  WIDTH  registered result (a - b - bin) mod 2^WIDTH
//   bout   out  1      borrow-out; 1 when unsigned a < b + bin
//   ovf    out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; diff/bout/ovf valid from this cycle
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; diff=0, bout=0, ovf=0, busy=0, done=0; count and shift regs cleared.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 at edge E0 latches a, b, bin into shift regs/borrow reg; count=0; go to RUN.
//   - RUN: busy=1. On each edge E1..E(WIDTH), process bit i=count:
//     d_i = a_i ^ b_i ^ brw
//     brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw)
//     Shift d_i into result reg at MSB (right-shift); count++.
//   - At E(WIDTH): load diff, bout=brw', and ovf; go to DONE.
//   - DONE: done=1 for exactly one cycle; busy=0; next edge returns to IDLE.
//   Latency: done is high in the cycle after E(WIDTH), i.e. WIDTH clocks after the start-sampling edge.
//   Back-to-back throughput: one op per WIDTH+2 clocks.
//   start while RUN or DONE: ignored. No queuing. Captured operands unaffected.
//   a/b/bin changes after acceptance: no effect on the running op.
//   diff/bout/ovf hold the previous result throughout RUN and IDLE. They update only at the RUN->DONE edge.
//   Count terminates at WIDTH-1 -> WIDTH transition. Never wraps.
//   Reset mid-RUN: abort immediately. Outputs return to reset values; next start behaves as after power-up.
//   Arithmetic is modulo 2^WIDTH. Borrow-in is treated as an extra LSB-weight subtrahend.
// TESTING (WIDTH=4)
//   1. a=0010 b=0001 bin=0, start 1 cycle -> done 4 clks later; diff=0001 bout=0 ovf=0; busy high 4 cycles.
//   2. a=0001 b=1111 bin=0 -> diff=0010 bout=1 ovf=0.
//   3. a=0101 b=1010 bin=1 -> diff=1010 bout=1 ovf=1.
//   4. a=1000 b=0001 bin=0 -> diff=0111 bout=0 ovf=1; during RUN, diff still shows prior result 1010.
//   5. start held high with new operands during RUN/DONE -> ignored; result matches first op.
//      Re-accepted only after return to IDLE.
//   6. rst_n low for 1 cycle at 2nd RUN edge -> busy=0 done=0 diff=0 bout=0 ovf=0 immediately.
//      Subsequent a=1111 b=1111 bin=0 -> diff=0000 bout=0.

Source files
------------

// File: rtl/ripple_borrow_subtractor_serial_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The sequencer drives the request side through master; the subtractor uses slave.
interface ripple_borrow_subtractor_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/ripple_borrow_subtractor_serial.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell walks the operand shift registers; results are published on done.
module ripple_borrow_subtractor_serial #(
  parameter int WIDTH = 4
) (
  input logic                             clk,
  input logic                             rst_n,
  ripple_borrow_subtractor_serial_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             brw;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             brw_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] res_nxt;

  // The full-subtractor cell; on the last bit a_i/b_i are the operand MSBs, which is what ovf needs.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d_i      = a_i ^ b_i ^ brw;
    brw_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & brw);
    last_bit = (count == CW'(WIDTH - 1));
    res_nxt  = {d_i, res_sh};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            brw    <= bus.bin;
            res_sh <= '0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_nxt[WIDTH-1:1];
          brw    <= brw_nxt;
          count  <= count + CW'(1);
          // Results stay frozen during RUN and change only on this final edge.
          if (last_bit) begin
            diff_q <= res_nxt;
            bout_q <= brw_nxt;
            ovf_q  <= (a_i ^ b_i) & (d_i ^ a_i);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_ripple_borrow_subtractor_serial.sv
// Self-checking bench for ripple_borrow_subtractor_serial (WIDTH=4).
// Expected results are queued at issue time and compared when done pulses.
module tb_ripple_borrow_subtractor_serial;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } result_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] lastDiff;
  result_t expQ[$];

  ripple_borrow_subtractor_serial_if #(.WIDTH(WIDTH)) bus ();

  ripple_borrow_subtractor_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide unsigned subtraction, ovf from operand/result sign bits.
  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    result_t r;
    logic [WIDTH:0] full;
    full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    r.diff = full[WIDTH-1:0];
    r.bout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.diff[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = expQ.pop_front();
        checkOutput("diff", 32'(bus.diff), 32'(e.diff));
        checkOutput("bout", 32'(bus.bout), 32'(e.bout));
        checkOutput("ovf", 32'(bus.ovf), 32'(e.ovf));
        checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
        lastDiff = e.diff;
      end
    end
  end

  // Waits from the cycle after acceptance until done, checking that diff holds its old value.
  task automatic waitDone(output int lat, output int busyCnt);
    lat     = 0;
    busyCnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busyCnt++;
      checkOutput("diff_hold", 32'(bus.diff), 32'(lastDiff));
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int lat;
    int busyCnt;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    expQ.push_back(model(a, b, bin));
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("latency", 32'(lat), 32'(WIDTH));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(WIDTH));
    @(negedge clk);
    checkOutput("done_pulse", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int lat;
    int busyCnt;
    checks    = 0;
    errors    = 0;
    lastDiff  = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    #12;
    checkOutput("rst_diff", 32'(bus.diff), 32'd0);
    checkOutput("rst_bout", 32'(bus.bout), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(4'b0010, 4'b0001, 1'b0);
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    applyStimulus(4'b0101, 4'b1010, 1'b1);
    applyStimulus(4'b1000, 4'b0001, 1'b0);

    // start held high with changing operands through RUN and DONE; only the first op runs
    @(negedge clk);
    bus.a = 4'b0011; bus.b = 4'b0101; bus.bin = 1'b0; bus.start = 1'b1;
    expQ.push_back(model(4'b0011, 4'b0101, 1'b0));
    @(negedge clk);
    bus.a = 4'b1110; bus.b = 4'b0100; bus.bin = 1'b1;
    waitDone(lat, busyCnt);
    checkOutput("held_latency", 32'(lat), 32'(WIDTH));
    @(negedge clk);
    checkOutput("held_done_pulse", 32'(bus.done), 32'd0);
    checkOutput("held_idle_busy", 32'(bus.busy), 32'd0);
    expQ.push_back(model(4'b1110, 4'b0100, 1'b1));
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("reaccept_latency", 32'(lat), 32'(WIDTH));
    @(negedge clk);

    // reset asserted just ahead of the second RUN edge
    @(negedge clk);
    bus.a = 4'b0110; bus.b = 4'b0011; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_diff", 32'(bus.diff), 32'd0);
    checkOutput("abort_bout", 32'(bus.bout), 32'd0);
    checkOutput("abort_ovf", 32'(bus.ovf), 32'd0);
    lastDiff = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(WIDTH'($urandom_range(15)), WIDTH'($urandom_range(15)), 1'($urandom_range(1)));
    end

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
